// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Loads a program image into the instruction memory before the CPU runs.
// Bytes come in on a valid/ready stream. Each group of four bytes is packed
// big-endian into a 32-bit word: the first byte lands in [31:24] and the
// fourth in [7:0]. The word is then written through the memory's cs/wr/rd
// port, one word per write, at consecutive word addresses starting at
// BASE_ADDR. The read strobe is never used here. The instruction unit reads
// the image back later, after the CPU leaves reset.
//
// Parameters
//   ADDR_W     byte-address width of the instruction memory
//   BASE_ADDR  byte address of the first word written (word aligned)
//   MAX_WORDS  upper bound on the words written in one load
//
// Ports
//   clk         system clock; all state changes on the rising edge
//   reset       synchronous, active-high
//   start       begin a load; only looked at while idle
//   load_len    number of words to load; captured together with start
//   byte_valid  byte_in carries a valid byte
//   byte_in     stream byte
//   byte_ready  loader takes a byte this cycle (valid & ready = transfer)
//   im_cs       instruction memory chip select
//   im_wr       instruction memory write strobe
//   im_rd       instruction memory read strobe (tied low)
//   im_addr     byte address of the current write
//   im_din      word being written
//   busy        high from the accepted start until the done pulse
//   done        one-cycle pulse after the last write (or straight away if
//               the length is zero)
//   word_count  words written in the current or most recent load
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int                ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [10:0]       load_len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_in,
    output logic              byte_ready,
    output logic              im_cs,
    output logic              im_wr,
    output logic              im_rd,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_din,
    output logic              busy,
    output logic              done,
    output logic [10:0]       word_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        FINISH  = 2'd3
    } state_t;

    localparam logic [10:0]       MAX_LEN   = 11'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

    state_t      state, state_next;
    logic [10:0] len;        // clamped length captured at start
    logic [1:0]  byte_idx;   // position of the next byte inside the word
    logic [10:0] len_clamped;
    logic        byte_xfer;
    logic        last_word;

    // Oversized requests are cut down to the memory capacity. This also
    // stops a load from wrapping round and writing one address twice.
    assign len_clamped = (load_len > MAX_LEN) ? MAX_LEN : load_len;
    assign byte_xfer   = (state == COLLECT) && byte_valid;
    assign last_word   = ((word_count + 11'd1) == len);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) assignments only. Every
    // register then takes the value from before the edge, whatever order
    // the statements are written in.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            im_addr    <= BASE_ADDR;
            im_din     <= '0;
            word_count <= '0;
            len        <= '0;
            byte_idx   <= '0;
        end else begin
            state <= state_next;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        len        <= len_clamped;
                        im_addr    <= BASE_ADDR;
                        word_count <= '0;
                        byte_idx   <= '0;
                    end
                end
                COLLECT: begin
                    // Shifting left puts the first byte of the group at
                    // [31:24] once all four bytes have arrived.
                    if (byte_xfer) begin
                        im_din   <= {im_din[23:0], byte_in};
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                WRITE: begin
                    // The address wraps naturally at 2**ADDR_W.
                    im_addr    <= im_addr + WORD_STEP;
                    word_count <= word_count + 11'd1;
                end
                FINISH: begin
                    // word_count and im_addr hold until the next start.
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: state_next gets its default before the case statement. Every
    // path through the block then assigns it, so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = (len_clamped == 11'd0) ? FINISH : COLLECT;
                end
            end
            COLLECT: begin
                if (byte_xfer && (byte_idx == 2'd3)) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                state_next = last_word ? FINISH : COLLECT;
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs decoded from the registered state
    // ------------------------------------------------------------------
    // These depend only on the state register. They are therefore glitch
    // free, and they take their reset values in the cycle after reset.
    always_comb begin
        byte_ready = 1'b0;
        im_cs      = 1'b0;
        im_wr      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: ;
            COLLECT: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
            WRITE: begin
                im_cs = 1'b1;
                im_wr = 1'b1;
                busy  = 1'b1;
            end
            FINISH: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: ;
        endcase
    end

    assign im_rd = 1'b0;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Directed bench for imem_loader. Two instances share every input:
//   dut  uses BASE_ADDR = 0x000
//   dut2 uses BASE_ADDR = 0xFFC, to exercise address wrap
// A negedge monitor logs each memory write and counts protocol violations.
// Each test compares those logs with words worked out by hand.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] load_len;
    logic        byte_valid;
    logic [7:0]  byte_in;

    logic        byte_ready, im_cs, im_wr, im_rd, busy, done;
    logic [11:0] im_addr;
    logic [31:0] im_din;
    logic [10:0] word_count;

    logic        byte_ready2, im_cs2, im_wr2, im_rd2, busy2, done2;
    logic [11:0] im_addr2;
    logic [31:0] im_din2;
    logic [10:0] word_count2;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(12), .BASE_ADDR(12'h000), .MAX_WORDS(1024)) dut (
        .clk(clk), .reset(reset), .start(start), .load_len(load_len),
        .byte_valid(byte_valid), .byte_in(byte_in), .byte_ready(byte_ready),
        .im_cs(im_cs), .im_wr(im_wr), .im_rd(im_rd), .im_addr(im_addr),
        .im_din(im_din), .busy(busy), .done(done), .word_count(word_count)
    );

    imem_loader #(.ADDR_W(12), .BASE_ADDR(12'hFFC), .MAX_WORDS(1024)) dut2 (
        .clk(clk), .reset(reset), .start(start), .load_len(load_len),
        .byte_valid(byte_valid), .byte_in(byte_in), .byte_ready(byte_ready2),
        .im_cs(im_cs2), .im_wr(im_wr2), .im_rd(im_rd2), .im_addr(im_addr2),
        .im_din(im_din2), .busy(busy2), .done(done2), .word_count(word_count2)
    );

    // ------------------------------------------------------------------
    // Monitor: outputs are stable at negedge
    // ------------------------------------------------------------------
    logic [11:0] wa_q[$];
    logic [31:0] wd_q[$];
    bit          seen[1024];
    int          dup_cnt     = 0;
    int          bad_ready   = 0;
    int          rd_cnt      = 0;
    int          cs_mismatch = 0;
    int          done_cnt    = 0;
    int          wr2_cnt     = 0;
    logic [11:0] wa2_last    = '0;
    logic [31:0] wd2_last    = '0;

    always @(negedge clk) begin
        if (!reset) begin
            if (!busy) begin
                for (int i = 0; i < 1024; i++) seen[i] = 1'b0;
            end
            if (im_cs && im_wr) begin
                wa_q.push_back(im_addr);
                wd_q.push_back(im_din);
                if (seen[im_addr[11:2]]) dup_cnt++;
                seen[im_addr[11:2]] = 1'b1;
            end
            if (im_wr && byte_ready) bad_ready++;
            if (im_rd || im_rd2) rd_cnt++;
            if (im_cs != im_wr) cs_mismatch++;
            if (done) done_cnt++;
            if (im_cs2 && im_wr2) begin
                wr2_cnt++;
                wa2_last = im_addr2;
                wd2_last = im_din2;
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Every task starts and ends on a negedge.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        byte_valid = 1'b1;
        byte_in    = b;
        n = 0;
        while (!byte_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("byte_ready_timeout", 32'(n), 32'd0);
        @(negedge clk);
        byte_valid = 1'b0;
        if (gap) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8],  gap);
        send_byte(w[7:0],   gap);
    endtask

    task automatic do_start(input logic [10:0] len);
        byte_valid = 1'b0;
        start      = 1'b1;
        load_len   = len;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Returns at the negedge where done is high.
    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int base;
    int dn;

    initial begin
        reset = 1'b1; start = 1'b0; load_len = '0;
        byte_valid = 1'b0; byte_in = '0;
        repeat (3) @(negedge clk);

        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_cs_wr_rd",   32'({im_cs, im_wr, im_rd}), 32'd0);
        check("rst_busy_done",  32'({busy, done}), 32'd0);
        check("rst_addr",       32'(im_addr), 32'h000);
        check("rst_addr2",      32'(im_addr2), 32'hFFC);
        check("rst_din",        im_din, 32'h0);
        check("rst_wcount",     32'(word_count), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Test 1: two words at full rate
        base = wa_q.size();
        do_start(11'd2);
        check("t1_busy", 32'(busy), 32'd1);
        send_word(32'h2008_0005, 1'b0);
        send_word(32'h8C09_0004, 1'b0);
        wait_done(20);
        check("t1_nwrites", 32'(wa_q.size() - base), 32'd2);
        check("t1_addr0", 32'(wa_q[base]), 32'h000);
        check("t1_data0", wd_q[base], 32'h2008_0005);
        check("t1_addr1", 32'(wa_q[base+1]), 32'h004);
        check("t1_data1", wd_q[base+1], 32'h8C09_0004);
        check("t1_wcount", 32'(word_count), 32'd2);
        check("t1_final_addr", 32'(im_addr), 32'h008);
        @(negedge clk);
        check("t1_done_pulse", 32'({busy, done}), 32'd0);
        check("t1_wcount_hold", 32'(word_count), 32'd2);

        // Test 2: zero-length load
        base = wa_q.size();
        do_start(11'd0);
        check("t2_done_next", 32'(done), 32'd1);
        @(negedge clk);
        check("t2_done_once", 32'({busy, done}), 32'd0);
        check("t2_wcount", 32'(word_count), 32'd0);
        repeat (3) @(negedge clk);
        check("t2_nwrites", 32'(wa_q.size() - base), 32'd0);

        // Test 3: byte_valid toggling 1/0
        base = wa_q.size();
        do_start(11'd2);
        send_word(32'h2008_0005, 1'b1);
        send_word(32'h8C09_0004, 1'b1);
        wait_done(20);
        check("t3_nwrites", 32'(wa_q.size() - base), 32'd2);
        check("t3_addr0", 32'(wa_q[base]), 32'h000);
        check("t3_data0", wd_q[base], 32'h2008_0005);
        check("t3_addr1", 32'(wa_q[base+1]), 32'h004);
        check("t3_data1", wd_q[base+1], 32'h8C09_0004);
        check("t3_ready_in_write", 32'(bad_ready), 32'd0);
        @(negedge clk);

        // Test 4: reset after the 3rd byte of word 2
        base = wa_q.size();
        do_start(11'd2);
        send_word(32'h1122_3344, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        send_byte(8'h77, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("t4_rst_ctl", 32'({byte_ready, im_cs, im_wr, im_rd, busy, done}), 32'd0);
        check("t4_rst_addr", 32'(im_addr), 32'h000);
        check("t4_rst_din", im_din, 32'h0);
        check("t4_rst_wcount", 32'(word_count), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("t4_nwrites", 32'(wa_q.size() - base), 32'd1);
        base = wa_q.size();
        do_start(11'd1);
        send_word(32'hA5A5_0F0F, 1'b0);
        wait_done(20);
        check("t4_reload_n", 32'(wa_q.size() - base), 32'd1);
        check("t4_reload_addr", 32'(wa_q[base]), 32'h000);
        check("t4_reload_data", wd_q[base], 32'hA5A5_0F0F);
        @(negedge clk);

        // Test 5: start while busy is ignored; wrap on dut2
        base = wa_q.size();
        dn   = wr2_cnt;
        do_start(11'd1);
        start = 1'b1; load_len = 11'd5;
        @(negedge clk);
        start = 1'b0;
        send_word(32'hDEAD_BEEF, 1'b0);
        wait_done(20);
        check("t5_wcount", 32'(word_count), 32'd1);
        check("t5_nwrites", 32'(wa_q.size() - base), 32'd1);
        check("t5_data", wd_q[base], 32'hDEAD_BEEF);
        check("t5_wrap_nwrites", 32'(wr2_cnt - dn), 32'd1);
        check("t5_wrap_waddr", 32'(wa2_last), 32'hFFC);
        check("t5_wrap_wdata", wd2_last, 32'hDEAD_BEEF);
        check("t5_wrap_final", 32'(im_addr2), 32'h000);
        repeat (3) @(negedge clk);
        check("t5_idle_after", 32'(busy), 32'd0);

        // Test 6: load_len = 2047 is clamped to 1024 words
        base = wa_q.size();
        do_start(11'd2047);
        for (int i = 0; i < 4096; i++) begin
            send_byte(8'(i), 1'b0);
            if (done) break;
        end
        wait_done(20);
        check("t6_nwrites", 32'(wa_q.size() - base), 32'd1024);
        check("t6_wcount", 32'(word_count), 32'd1024);
        check("t6_first_addr", 32'(wa_q[base]), 32'h000);
        check("t6_first_data", wd_q[base], 32'h0001_0203);
        check("t6_last_addr", 32'(wa_q[base+1023]), 32'hFFC);
        check("t6_last_data", wd_q[base+1023], 32'hFCFD_FEFF);
        check("t6_final_addr", 32'(im_addr), 32'h000);
        repeat (10) @(negedge clk);
        check("t6_no_extra", 32'(wa_q.size() - base), 32'd1024);

        // Violations accumulated over the whole run
        check("dup_addr", 32'(dup_cnt), 32'd0);
        check("ready_in_write", 32'(bad_ready), 32'd0);
        check("rd_never", 32'(rd_cnt), 32'd0);
        check("cs_eq_wr", 32'(cs_mismatch), 32'd0);
        check("done_cycles", 32'(done_cnt), 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
